// File: rtl/jt6295_pkg.sv
// Shared definitions for the jt6295 command scheduler slice: FSM encoding,
// command byte bit positions and default geometry.
package jt6295_pkg;

  localparam int CH_DEF   = 4;
  localparam int PHW_DEF  = 7;
  localparam int ATTW_DEF = 4;

  localparam int CMD_PHRASE_BIT = 7;
  localparam int STOP_MASK_LSB  = 3;
  localparam int START_MASK_LSB = 4;
  localparam int ATT_LSB        = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

endpackage

// File: rtl/jt6295_req_slot.sv
// One channel's pending start/stop request and its phrase/attenuation entry.
// A set in the same clk as a clear wins, so a request written while the
// channel is being serviced survives until the next slot round.
module jt6295_req_slot #(
  parameter int PHW  = 7,
  parameter int ATTW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_start,
  input  logic            set_stop,
  input  logic            clr,
  input  logic [PHW-1:0]  ph_in,
  input  logic [ATTW-1:0] att_in,
  output logic            start_pend,
  output logic            stop_pend,
  output logic [PHW-1:0]  ph,
  output logic [ATTW-1:0] att
);

  // Request flags and entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pend <= 1'b0;
      stop_pend  <= 1'b0;
      ph         <= '0;
      att        <= '0;
    end else begin
      if (set_start) begin
        start_pend <= 1'b1;
        ph         <= ph_in;
        att        <= att_in;
      end else if (clr) begin
        start_pend <= 1'b0;
      end
      if (set_stop)  stop_pend <= 1'b1;
      else if (clr)  stop_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/jt6295_cmd_sched.sv
// Command decoder and slot scheduler for the time-multiplexed ADPCM voice loop.
// Optional macro JT6295_STATUS_PEND_EN: status (and the busy check) also
// include channels with an accepted but not yet serviced start.
module jt6295_cmd_sched
  import jt6295_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int SLOTW = 2,
  parameter int PHW   = PHW_DEF,
  parameter int ATTW  = ATTW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             wrn,
  input  logic [7:0]       din,
  input  logic [CH-1:0]    busy_in,
  output logic [SLOTW-1:0] slot,
  output logic             start,
  output logic             stop,
  output logic [PHW-1:0]   phrase,
  output logic [ATTW-1:0]  att,
  output logic [CH-1:0]    status,
  output logic             cmd_err
);

  state_t           st;
  logic             wrn_l;
  logic             we;
  logic [PHW-1:0]   ph_lat;
  logic [SLOTW-1:0] cnt;
  logic [CH-1:0]    status_q;
  logic [CH-1:0]    busy_chk;
  logic [CH-1:0]    start_pend, stop_pend;
  logic [CH-1:0]    set_start, set_stop, clr;
  logic             reject;
  logic [PHW-1:0]   ent_ph  [CH];
  logic [ATTW-1:0]  ent_att [CH];
  logic [3:0]       stop_m, start_m;

  assign we      = wrn_l & ~wrn;
  assign stop_m  = din[STOP_MASK_LSB +: 4];
  assign start_m = din[START_MASK_LSB +: 4];

`ifdef JT6295_STATUS_PEND_EN
  assign busy_chk = status_q | start_pend;
  assign status   = status_q | start_pend;
`else
  assign busy_chk = status_q;
  assign status   = status_q;
`endif

  // Per-channel request set/clear decode from the current write and slot
  always_comb begin
    set_start = '0;
    set_stop  = '0;
    clr       = '0;
    reject    = 1'b0;
    for (int unsigned i = 0; i < CH; i++) begin
      clr[i] = cen && (cnt == SLOTW'(i));
      if (i < 4) begin
        if (we && st == IDLE && !din[CMD_PHRASE_BIT])
          set_stop[i] = stop_m[i[1:0]];
        if (we && st == ARMED && start_m[i[1:0]]) begin
          if (busy_chk[i]) reject       = 1'b1;
          else             set_start[i] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_slot
    jt6295_req_slot #(.PHW(PHW), .ATTW(ATTW)) u_req (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_start  (set_start[g]),
      .set_stop   (set_stop[g]),
      .clr        (clr[g]),
      .ph_in      (ph_lat),
      .att_in     (din[ATT_LSB +: ATTW]),
      .start_pend (start_pend[g]),
      .stop_pend  (stop_pend[g]),
      .ph         (ent_ph[g]),
      .att        (ent_att[g])
    );
  end

  // Command FSM: phrase byte arms, next byte issues starts; stop bytes in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrn_l   <= 1'b1;
      st      <= IDLE;
      ph_lat  <= '0;
      cmd_err <= 1'b0;
    end else begin
      wrn_l <= wrn;
      if (we) begin
        case (st)
          IDLE: begin
            if (din[CMD_PHRASE_BIT]) begin
              ph_lat  <= din[PHW-1:0];
              cmd_err <= 1'b0;
              st      <= ARMED;
            end
          end
          ARMED: begin
            if (reject) cmd_err <= 1'b1;
            st <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  // Slot scheduler: slot output is registered alongside the strobes it qualifies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      slot     <= '0;
      start    <= 1'b0;
      stop     <= 1'b0;
      phrase   <= '0;
      att      <= '0;
      status_q <= '0;
    end else begin
      start <= 1'b0;
      stop  <= 1'b0;
      if (cen) begin
        slot          <= cnt;
        cnt           <= cnt + 1'b1;
        status_q[cnt] <= busy_in[cnt];
        if (stop_pend[cnt]) begin
          stop <= 1'b1;
        end else if (start_pend[cnt]) begin
          start  <= 1'b1;
          phrase <= ent_ph[cnt];
          att    <= ent_att[cnt];
        end
      end
    end
  end

endmodule

// File: tb/tb_jt6295_cmd_sched.sv
// Directed self-checking bench for jt6295_cmd_sched (default 4-channel build).
module tb_jt6295_cmd_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic       wrn;
  logic [7:0] din;
  logic [3:0] busy_in;
  logic [1:0] slot;
  logic       start, stop;
  logic [6:0] phrase;
  logic [3:0] att;
  logic [3:0] status;
  logic       cmd_err;

  int n_cmp = 0;
  int n_err = 0;

  jt6295_cmd_sched #(.CH(4), .SLOTW(2), .PHW(7), .ATTW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .wrn     (wrn),
    .din     (din),
    .busy_in (busy_in),
    .slot    (slot),
    .start   (start),
    .stop    (stop),
    .phrase  (phrase),
    .att     (att),
    .status  (status),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] b);
    wrn = 1'b0;
    din = b;
    tick();
    wrn = 1'b1;
    tick();
  endtask

  task automatic cen_tick(input string tag, input logic [1:0] es, input logic est, input logic esp);
    cen = 1'b1;
    tick();
    cen = 1'b0;
    chk({tag, ".slot"},  slot,  es);
    chk({tag, ".start"}, start, est);
    chk({tag, ".stop"},  stop,  esp);
  endtask

  task automatic quiet_round(input string tag);
    cen_tick(tag, 2'd0, 1'b0, 1'b0);
    cen_tick(tag, 2'd1, 1'b0, 1'b0);
    cen_tick(tag, 2'd2, 1'b0, 1'b0);
    cen_tick(tag, 2'd3, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b0; wrn = 1'b1; din = 8'h00; busy_in = 4'h0;
    tick(); tick(); tick();
    chk("rst.slot", slot, 2'd0);
    chk("rst.start", start, 1'b0);
    chk("rst.stop", stop, 1'b0);
    chk("rst.phrase", phrase, 7'd0);
    chk("rst.att", att, 4'd0);
    chk("rst.status", status, 4'h0);
    chk("rst.cmd_err", cmd_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // advance slot, leave stops pending and FSM armed, then reset mid-command
    cen_tick("pre", 2'd0, 1'b0, 1'b0);
    cen_tick("pre", 2'd1, 1'b0, 1'b0);
    cpu_write(8'h28);
    cpu_write(8'h81);
    rst_n = 1'b0;
    #1;
    chk("rst2.slot", slot, 2'd0);
    chk("rst2.start", start, 1'b0);
    chk("rst2.stop", stop, 1'b0);
    chk("rst2.status", status, 4'h0);
    chk("rst2.cmd_err", cmd_err, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    // 0x10 in IDLE is stop ch1 (in ARMED it would be start ch0)
    cpu_write(8'h10);
    cen_tick("rst2", 2'd0, 1'b0, 1'b0);
    cen_tick("rst2", 2'd1, 1'b0, 1'b1);
    cen_tick("rst2", 2'd2, 1'b0, 1'b0);
    cen_tick("rst2", 2'd3, 1'b0, 1'b0);

    // start ch1, phrase 5, att 3
    cpu_write(8'h85);
    cpu_write(8'h23);
    cen_tick("start", 2'd0, 1'b0, 1'b0);
    cen_tick("start", 2'd1, 1'b1, 1'b0);
    chk("start.phrase", phrase, 7'd5);
    chk("start.att", att, 4'd3);
    cen_tick("start", 2'd2, 1'b0, 1'b0);
    cen_tick("start", 2'd3, 1'b0, 1'b0);
    quiet_round("start2");
    chk("hold.phrase", phrase, 7'd5);
    chk("hold.att", att, 4'd3);

    // stop ch0 and ch2
    cpu_write(8'h28);
    cen_tick("stop", 2'd0, 1'b0, 1'b1);
    cen_tick("stop", 2'd1, 1'b0, 1'b0);
    cen_tick("stop", 2'd2, 1'b0, 1'b1);
    cen_tick("stop", 2'd3, 1'b0, 1'b0);

    // start ch3 then stop ch3 before its slot: stop wins
    cpu_write(8'h8A);
    cpu_write(8'h85);
    cpu_write(8'h40);
    cen_tick("coll", 2'd0, 1'b0, 1'b0);
    cen_tick("coll", 2'd1, 1'b0, 1'b0);
    cen_tick("coll", 2'd2, 1'b0, 1'b0);
    cen_tick("coll", 2'd3, 1'b0, 1'b1);
    quiet_round("coll2");
    chk("coll.phrase", phrase, 7'd5);
    chk("coll.att", att, 4'd3);

    // busy reject on ch2
    busy_in = 4'b0100;
    quiet_round("busy");
    chk("busy.status", status, 4'b0100);
    cpu_write(8'h81);
    cpu_write(8'h40);
    chk("busy.cmd_err", cmd_err, 1'b1);
    quiet_round("busy2");
    chk("busy.err_sticky", cmd_err, 1'b1);
    cpu_write(8'h80);
    chk("busy.err_clr", cmd_err, 1'b0);
    cpu_write(8'h00);
    busy_in = 4'h0;
    quiet_round("zmask");
    chk("zmask.status", status, 4'h0);
    chk("zmask.cmd_err", cmd_err, 1'b0);

    // cen gating: start ch0 pending while cen is low
    cpu_write(8'h87);
    cpu_write(8'h1F);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate.start", start, 1'b0);
      chk("gate.slot", slot, 2'd3);
    end
    cen_tick("gate", 2'd0, 1'b1, 1'b0);
    chk("gate.phrase", phrase, 7'd7);
    chk("gate.att", att, 4'hF);
    cen_tick("gate", 2'd1, 1'b0, 1'b0);
    cen_tick("gate", 2'd2, 1'b0, 1'b0);
    cen_tick("gate", 2'd3, 1'b0, 1'b0);

    // second start to an already pending channel
    cpu_write(8'h81);
    cpu_write(8'h12);
    cpu_write(8'h83);
    cpu_write(8'h14);
`ifdef JT6295_STATUS_PEND_EN
    chk("pend.cmd_err", cmd_err, 1'b1);
    chk("pend.status", status, 4'b0001);
    cen_tick("pend", 2'd0, 1'b1, 1'b0);
    chk("pend.phrase", phrase, 7'd1);
    chk("pend.att", att, 4'd2);
`else
    chk("pend.cmd_err", cmd_err, 1'b0);
    chk("pend.status", status, 4'b0000);
    cen_tick("pend", 2'd0, 1'b1, 1'b0);
    chk("pend.phrase", phrase, 7'd3);
    chk("pend.att", att, 4'd4);
`endif
    cen_tick("pend", 2'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jt6295_cmd_sched.md
Name: jt6295_cmd_sched

Overview:
- Command decoder and slot scheduler for the time-multiplexed ADPCM voice loop.
- Accepts CPU writes (MSM6295 protocol: phrase byte, then channel/attenuation byte; or stop byte).
- Holds per-channel pending start/stop requests and releases each request only in that channel's time slot.
- Slot index, start/stop strobes and the latched phrase/attenuation feed the per-channel state shift registers. Channel busy flags return from the voice loop.

Parameters:
- CH, 4, number of voice channels/slots; power of two, 2..8.
- SLOTW, 2, slot counter width, equal to log2(CH).
- PHW, 7, phrase index width.
- ATTW, 4, attenuation code width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  slot advance enable; one slot per cen cycle
- wrn  in  1  CPU write strobe, active-low, synchronous to clk
- din  in  8  CPU data bus
- busy_in  in  CH  per-channel playing flag from voice loop, valid in current slot
- slot  out  SLOTW  channel index owning the current cen cycle
- start  out  1  start strobe for channel = slot
- stop  out  1  stop strobe for channel = slot
- phrase  out  PHW  phrase index qualifying start
- att  out  ATTW  attenuation qualifying start
- status  out  CH  CPU-readable busy flags
- cmd_err  out  1  sticky: start requested on busy channel; cleared on next phrase byte

Behaviour:
- Reset (rst_n low, async): slot=0, start=0, stop=0, phrase=0, att=0, status=0, cmd_err=0, FSM=IDLE, all pending bits=0.
- Write detect: falling edge of wrn (registered previous value); one command byte per edge; din sampled on the edge cycle.
- FSM IDLE:
  - din[7]=1: latch din[6:0] to phrase register; go to ARMED.
  - din[7]=0: for each set bit of din[6:3] (bit3=ch0), set stop_pend; stay in IDLE. Mask bits at or above CH are ignored.
- FSM ARMED, next write:
  - din[7:4] is the channel mask (bit4=ch0); din[3:0] is att.
  - For each masked channel, set start_pend and store phrase/att into that channel's request entry.
  - A masked channel already busy (status bit set) gets no request and sets cmd_err.
  - Return to IDLE.
  - A zero mask returns to IDLE with no effect.
- Slot counter: increments mod CH on every cen; holds otherwise.
- Strobes: registered; asserted only in the cen cycle where slot equals the channel, for exactly one clk; cleared next clk.
  - start=1 when start_pend[slot] is set and stop_pend[slot] is clear. phrase/att are driven from that channel's entry in the same cycle, and start_pend[slot] clears.
  - stop=1 when stop_pend[slot] is set. It clears both stop_pend[slot] and start_pend[slot]; stop wins on collision.
- Latency: a request is serviced at the first cen whose slot matches. Worst case is CH cen cycles after the write.
- status[slot] updates from busy_in on each cen; other bits hold.
- Write in the same clk as a service of the same channel: service uses the old pending state; the new request lands next slot round.
- phrase/att hold their last values when start=0.
- Reset mid-command: ARMED is abandoned and all pending requests are lost.

Optional Feature:
- Macro JT6295_STATUS_PEND_EN.
- Defined: status bit = busy_in-sampled flag OR start_pend for that channel, so the CPU sees a channel busy as soon as the start is accepted. A start byte to a channel with start_pend set is treated as busy and sets cmd_err.
- Undefined: status reflects only sampled busy_in; a second start to a pending channel overwrites that channel's phrase/att entry.

Decomposition:
- Shared package jt6295_pkg holds:
  - FSM state encoding: IDLE=0, ARMED=1.
  - Command bit positions: CMD_PHRASE_BIT=7, STOP_MASK_LSB=3, START_MASK_LSB=4, ATT_LSB=0.
  - Default CH/PHW/ATTW.
- One sub-module, jt6295_req_slot, instantiated CH times. Each holds one channel's start_pend, stop_pend, phrase and att entry, with set/clear ports.

Test Plan:
- Reset: rst_n low mid-ARMED with pending bits set -> all outputs 0, FSM IDLE; first cen after release gives slot=0.
- Start: write 0x85 then 0x23 (ch1, att=3) with cen every clk -> start=1 at slot=1, phrase=5, att=3; no strobe at slots 0/2/3; start_pend[1] clears.
- Stop: write 0x28 (stop ch0 and ch2) -> stop=1 at slot 0 and slot 2, one clk each; no start.
- Collision: start ch3, then stop ch3 written before slot 3 -> stop=1, start never asserted for ch3.
- Busy reject: busy_in[2]=1 sampled, then write 0x81 and 0x40 -> no start in slot 2, cmd_err=1; next 0x80 clears cmd_err.
- cen gating: cen low for 10 clks after a start-ch0 request -> slot holds and no strobes; strobes resume correctly when cen returns.
